// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: splits a launch into fixed-size thread blocks and
// hands one block per cycle to the lowest-index idle core, counting retirements.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int MAX_THREADS       = 256,
    localparam int TC_W  = $clog2(MAX_THREADS) + 1,
    localparam int BID_W = $clog2(MAX_THREADS),
    localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [TC_W-1:0]            total_threads,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*BID_W-1:0] core_block_id,
    output logic [NUM_CORES*CNT_W-1:0] core_thread_count,
    input  logic [NUM_CORES-1:0]       core_done,
    output logic                       done
);

    localparam int              LOG_TPB  = $clog2(THREADS_PER_BLOCK);
    localparam logic [TC_W-1:0] TPB_TC   = TC_W'(THREADS_PER_BLOCK);
    localparam logic [TC_W-1:0] ROUND_UP = TC_W'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic                  launch;
    logic [TC_W-1:0]       kernel_threads;
    logic [TC_W-1:0]       total_blocks;
    logic [TC_W-1:0]       dispatched;
    logic [TC_W-1:0]       retired;
    logic [TC_W-1:0]       retire_count;
    logic [TC_W-1:0]       remaining;
    logic [CNT_W-1:0]      block_count;
    logic [NUM_CORES-1:0]  retire;
    logic [NUM_CORES-1:0]  grant;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // An empty kernel still spends one cycle in RUN, so done follows the
    // same "one edge after the last retire" timing as a real kernel.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (retired == total_blocks) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Scanning from the top down lets the lowest idle core win the grant.
    always_comb begin
        grant = '0;
        if (state == RUN && dispatched < total_blocks) begin
            for (int c = NUM_CORES - 1; c >= 0; c--) begin
                if (!core_start[c]) begin
                    grant    = '0;
                    grant[c] = 1'b1;
                end
            end
        end
    end

    assign retire = core_start & core_done;

    always_comb begin
        retire_count = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            retire_count = retire_count + TC_W'(retire[c]);
        end
    end

    assign remaining   = kernel_threads - (dispatched << LOG_TPB);
    assign block_count = (remaining >= TPB_TC) ? CNT_W'(THREADS_PER_BLOCK)
                                               : remaining[CNT_W-1:0];

    // Block id and thread count persist after retirement; only core_start drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            kernel_threads    <= '0;
            total_blocks      <= '0;
            dispatched        <= '0;
            retired           <= '0;
        end else if (launch) begin
            kernel_threads <= total_threads;
            total_blocks   <= (total_threads + ROUND_UP) >> LOG_TPB;
            dispatched     <= '0;
            retired        <= '0;
        end else begin
            retired    <= retired + retire_count;
            core_start <= (core_start & ~retire) | grant;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (grant[c]) begin
                    core_block_id[c*BID_W +: BID_W]     <= dispatched[BID_W-1:0];
                    core_thread_count[c*CNT_W +: CNT_W] <= block_count;
                end
            end
            if (|grant) dispatched <= dispatched + TC_W'(1);
        end
    end

    assign done = (state == DONE);

endmodule
